// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, ROM address, IF/ID register, stall/flush/redirect, fetch counter.
// Optional alignment/range fault checking is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    logic [63:0] r_pc;
    logic [63:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_valid;
    logic [31:0] r_count;
    logic [63:0] w_next_pc;
    logic        w_bubble;

    // Branch beats stall; a stalled PC simply re-presents the same address.
    always_comb begin
        w_next_pc = r_pc;
        if (br_taken) begin
`ifdef FETCH_ALIGN_CHECK_EN
            w_next_pc = br_target;
`else
            w_next_pc = br_target & ~64'd3;
`endif
        end else if (!stall) begin
            w_next_pc = r_pc + 64'd4;
        end
    end

    assign w_bubble = br_taken || flush;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    logic [0:0]  r_state;
    logic        r_fault;
    logic [64:0] w_next_end;
    logic        w_fault;

    assign w_next_end  = {1'b0, w_next_pc} + 65'd3;
    assign w_fault     = (w_next_pc[1:0] != 2'b00) || (w_next_end >= 65'(IMEM_BYTES));
    assign fetch_fault = r_fault;
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc       <= RESET_PC;
            r_if_pc    <= 64'd0;
            r_if_instr <= 32'd0;
            r_if_valid <= 1'b0;
            r_count    <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault    <= 1'b0;
            r_state    <= ST_RUN;
        end else if (r_state == ST_FAULT) begin
            r_if_pc    <= 64'd0;
            r_if_instr <= 32'd0;
            r_if_valid <= 1'b0;
        end else if (w_fault) begin
            r_fault    <= 1'b1;
            r_state    <= ST_FAULT;
            r_if_pc    <= 64'd0;
            r_if_instr <= 32'd0;
            r_if_valid <= 1'b0;
`endif
        end else begin
            r_pc <= w_next_pc;
            if (w_bubble) begin
                r_if_pc    <= 64'd0;
                r_if_instr <= 32'd0;
                r_if_valid <= 1'b0;
            end else if (!stall) begin
                r_if_pc    <= r_pc;
                r_if_instr <= imem_instr;
                r_if_valid <= 1'b1;
                r_count    <= r_count + 32'd1;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign if_pc       = r_if_pc;
    assign if_instr    = r_if_instr;
    assign if_valid    = r_if_valid;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a behavioural model.
module tb_fetch_stage;

    localparam logic [63:0] RESET_PC   = 64'd0;
    localparam int unsigned IMEM_BYTES = 1024;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
    logic [63:0] br_target = 64'd0;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid, fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] rom [256];
    int n_pass = 0;
    int n_total = 0;

    logic [63:0] m_pc;
    logic [63:0] m_if_pc;
    logic [31:0] m_instr;
    logic        m_valid, m_fault;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_addr[9:2]];

    fetch_stage #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .stall(stall), .flush(flush), .br_taken(br_taken), .br_target(br_target),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return rom[a[9:2]];
    endfunction

    // Apply one edge's inputs, advance the model by the spec's rules, then sample after the edge.
    task automatic step(input logic rn, input logic st, input logic fl, input logic bt,
                        input logic [63:0] tgt);
        logic [63:0] cand;
        logic        bad;
        reset_n = rn; stall = st; flush = fl; br_taken = bt; br_target = tgt;
        cand = bt ? (ALIGN_CHK ? tgt : {tgt[63:2], 2'b00}) : (st ? m_pc : m_pc + 64'd4);
        bad  = ALIGN_CHK && ((cand[1:0] != 2'b00) || ({1'b0, cand} + 65'd3 >= 65'(IMEM_BYTES)));
        if (!rn) begin
            m_pc = RESET_PC; m_if_pc = '0; m_instr = '0; m_valid = 0; m_cnt = '0; m_fault = 0;
        end else if (m_fault || bad) begin
            m_fault = 1; m_if_pc = '0; m_instr = '0; m_valid = 0;
        end else begin
            if (bt || fl) begin
                m_if_pc = '0; m_instr = '0; m_valid = 0;
            end else if (!st) begin
                m_if_pc = m_pc; m_instr = rom_word(m_pc); m_valid = 1; m_cnt = m_cnt + 1;
            end
            m_pc = cand;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 64'd0);
        step(0, 1, 1, 1, 64'h80);
        n_total++; if (imem_addr !== RESET_PC) $display("FAIL reset_addr got %h want %h", imem_addr, RESET_PC); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_valid); else n_pass++;
        n_total++; if (if_instr !== 32'd0 || if_pc !== 64'd0) $display("FAIL reset_ifid got %h/%h want 0/0", if_pc, if_instr); else n_pass++;
        n_total++; if (fetch_count !== 32'd0 || fetch_fault !== 1'b0) $display("FAIL reset_cnt got %0d/%b want 0/0", fetch_count, fetch_fault); else n_pass++;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 64'd0);
            n_total++;
            if (if_pc !== 64'(4 * i) || if_instr !== rom[i] || if_valid !== 1'b1)
                $display("FAIL seq_%0d got pc %h instr %h v %b want pc %h instr %h v 1", i, if_pc, if_instr, if_valid, 64'(4 * i), rom[i]);
            else n_pass++;
        end
        n_total++; if (fetch_count !== 32'd4) $display("FAIL seq_count got %0d want 4", fetch_count); else n_pass++;
    endtask

    task automatic test_stall();
        step(0, 0, 0, 0, 64'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 64'd0);
            n_total++;
            if (if_pc !== 64'd8 || imem_addr !== 64'd12 || fetch_count !== 32'd3)
                $display("FAIL stall_hold_%0d got pc %h addr %h cnt %0d want 8 c 3", i, if_pc, imem_addr, fetch_count);
            else n_pass++;
        end
        step(1, 0, 0, 0, 64'd0);
        n_total++; if (if_pc !== 64'd12 || if_instr !== rom[3]) $display("FAIL stall_release got %h/%h want c/%h", if_pc, if_instr, rom[3]); else n_pass++;
    endtask

    task automatic test_branch_stall();
        step(1, 1, 0, 1, 64'h40);
        n_total++; if (if_valid !== 1'b0 || imem_addr !== 64'h40) $display("FAIL br_bubble got v %b addr %h want v 0 addr 40", if_valid, imem_addr); else n_pass++;
        step(1, 0, 0, 0, 64'd0);
        n_total++; if (if_pc !== 64'h40 || if_instr !== rom[16] || if_valid !== 1'b1) $display("FAIL br_target got %h/%h want 40/%h", if_pc, if_instr, rom[16]); else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] cnt0;
        step(1, 0, 0, 1, 64'h10);
        cnt0 = fetch_count;
        step(1, 0, 1, 0, 64'd0);
        n_total++; if (if_valid !== 1'b0 || if_instr !== 32'd0) $display("FAIL flush_bubble got v %b instr %h want 0/0", if_valid, if_instr); else n_pass++;
        n_total++; if (imem_addr !== 64'h14 || fetch_count !== cnt0) $display("FAIL flush_pc got %h cnt %0d want 14 cnt %0d", imem_addr, fetch_count, cnt0); else n_pass++;
    endtask

    task automatic test_misaligned();
        step(1, 0, 0, 1, 64'h42);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(1, $urandom_range(0, 1), 0, $urandom_range(0, 1), 64'h80);
            n_total++;
            if (fetch_fault !== 1'b1 || imem_addr !== 64'h14 || if_valid !== 1'b0)
                $display("FAIL fault_hold_%0d got f %b addr %h v %b want 1/14/0", i, fetch_fault, imem_addr, if_valid);
            else n_pass++;
        end
        step(0, 0, 0, 0, 64'd0);
        n_total++; if (fetch_fault !== 1'b0 || imem_addr !== RESET_PC) $display("FAIL fault_reset got f %b addr %h want 0/%h", fetch_fault, imem_addr, RESET_PC); else n_pass++;
`else
        n_total++; if (imem_addr !== 64'h40 || fetch_fault !== 1'b0) $display("FAIL misalign got addr %h f %b want 40/0", imem_addr, fetch_fault); else n_pass++;
        step(1, 0, 0, 1, 64'h3FC);
        step(1, 0, 0, 0, 64'd0);
        n_total++; if (imem_addr !== 64'h400 || fetch_fault !== 1'b0) $display("FAIL rom_end got addr %h f %b want 400/0", imem_addr, fetch_fault); else n_pass++;
        step(1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1, 0, 0, 0, 64'd0);
        n_total++; if (imem_addr !== 64'd0 || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL pc_wrap got addr %h ifpc %h want 0/fffffffffffffffc", imem_addr, if_pc); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [63:0] tgt;
        step(0, 0, 0, 0, 64'd0);
        for (int i = 0; i < 400; i++) begin
            tgt = {54'd0, 10'($urandom_range(0, 1023))};
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, tgt);
            n_total++;
            if (imem_addr !== m_pc || if_pc !== m_if_pc || if_instr !== m_instr || if_valid !== m_valid ||
                fetch_count !== m_cnt || fetch_fault !== m_fault)
                $display("FAIL rand_%0d got %h %h %h %b %0d %b want %h %h %h %b %0d %b", i,
                         imem_addr, if_pc, if_instr, if_valid, fetch_count, fetch_fault,
                         m_pc, m_if_pc, m_instr, m_valid, m_cnt, m_fault);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {$urandom} ^ 32'(i << 24) ^ 32'(i);
        m_pc = RESET_PC; m_if_pc = '0; m_instr = '0; m_valid = 0; m_cnt = '0; m_fault = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_stall();
        test_flush();
        test_misaligned();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
